dadda_mul16_seq: RTL and testbench

Multi-cycle 16x16 unsigned multiplier controller. It time-shares one 8x8 Dadda multiplier instance across four byte-pair products and accumulates them into a 32-bit result. Operands come in and the result goes out over valid/ready handshakes. It sits between an operand producer (CPU/accelerator datapath) and the existing 8x8 Dadda multiplier datapath.

---
 rtl/dadda_mul16_seq_pkg.sv | 17 +
 rtl/dadda_mul16_seq_if.sv | 20 ++
 rtl/dadda_mul16_seq_dadda.sv | 99 +++++++++
 rtl/dadda_mul16_seq.sv | 118 +++++++++++
 tb/tb_dadda_mul16_seq.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dadda_mul16_seq_pkg.sv
// Shared types and constants for the 16x16 sequential multiplier built on one 8x8 Dadda core.
package dadda_mul16_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int STEP_W    = 2;
    localparam int NUM_STEPS = 4;

    // Weight of each byte-pair product: lo*lo, hi*lo, lo*hi, hi*hi.
    localparam int SHIFT_AMT [NUM_STEPS] = '{0, 8, 8, 16};

endpackage

// File: rtl/dadda_mul16_seq_if.sv
// Operand/result valid-ready bundle between the producer and the multiplier controller.
interface dadda_mul16_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, res
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, res
    );
endinterface

// File: rtl/dadda_mul16_seq_dadda.sv
// Combinational 8x8 unsigned Dadda multiplier: column reduction 8->6->4->3->2, then one final add.
module dadda (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] x
);
    localparam int W      = 16;
    localparam int H      = 8;
    localparam int NSTAGE = 4;
    localparam int D_SEQ [NSTAGE] = '{6, 4, 3, 2};

    logic       cur [W][H];
    logic       nxt [W][H];
    logic [3:0] cnt [W];
    logic [3:0] ncnt [W];
    logic [3:0] idx;
    logic [3:0] rem;
    logic [3:0] hgt;
    logic       s;
    logic       cy;
    logic [W-1:0] row0;
    logic [W-1:0] row1;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        for (int c = 0; c < W; c++) begin
            cnt[c]  = '0;
            ncnt[c] = '0;
            for (int k = 0; k < H; k++) begin
                cur[c][k] = 1'b0;
                nxt[c][k] = 1'b0;
            end
        end
        idx  = '0;
        rem  = '0;
        hgt  = '0;
        s    = 1'b0;
        cy   = 1'b0;
        row0 = '0;
        row1 = '0;

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                cur[i+j][cnt[i+j][2:0]] = a[i] & b[j];
                cnt[i+j] = cnt[i+j] + 4'd1;
            end
        end

        for (int st = 0; st < NSTAGE; st++) begin
            for (int c = 0; c < W; c++) begin
                ncnt[c] = '0;
                for (int k = 0; k < H; k++) nxt[c][k] = 1'b0;
            end
            for (int c = 0; c < W; c++) begin
                idx = '0;
                // Height counts carries already pushed in from the column to the right.
                for (int it = 0; it < 6; it++) begin
                    rem = cnt[c] - idx;
                    hgt = rem + ncnt[c];
                    if (32'(hgt) > D_SEQ[st] && rem >= 4'd2) begin
                        if (32'(hgt) == D_SEQ[st] + 1 || rem == 4'd2) begin
                            s   = cur[c][idx[2:0]] ^ cur[c][idx[2:0]+3'd1];
                            cy  = cur[c][idx[2:0]] & cur[c][idx[2:0]+3'd1];
                            idx = idx + 4'd2;
                        end else begin
                            s   = cur[c][idx[2:0]] ^ cur[c][idx[2:0]+3'd1] ^ cur[c][idx[2:0]+3'd2];
                            cy  = (cur[c][idx[2:0]] & cur[c][idx[2:0]+3'd1])
                                | (cur[c][idx[2:0]] & cur[c][idx[2:0]+3'd2])
                                | (cur[c][idx[2:0]+3'd1] & cur[c][idx[2:0]+3'd2]);
                            idx = idx + 4'd3;
                        end
                        nxt[c][ncnt[c][2:0]] = s;
                        ncnt[c] = ncnt[c] + 4'd1;
                        if (c < W - 1) begin
                            nxt[c+1][ncnt[c+1][2:0]] = cy;
                            ncnt[c+1] = ncnt[c+1] + 4'd1;
                        end
                    end
                end
                for (int k = 0; k < H; k++) begin
                    if (4'(k) >= idx && 4'(k) < cnt[c]) begin
                        nxt[c][ncnt[c][2:0]] = cur[c][k];
                        ncnt[c] = ncnt[c] + 4'd1;
                    end
                end
            end
            for (int c = 0; c < W; c++) begin
                cnt[c] = ncnt[c];
                for (int k = 0; k < H; k++) cur[c][k] = nxt[c][k];
            end
        end

        for (int c = 0; c < W; c++) begin
            row0[c] = (cnt[c] > 4'd0) ? cur[c][0] : 1'b0;
            row1[c] = (cnt[c] > 4'd1) ? cur[c][1] : 1'b0;
        end
        x = row0 + row1;
    end
endmodule

// File: rtl/dadda_mul16_seq.sv
// 16x16 unsigned multiplier: four byte-pair products through one 8x8 Dadda core, summed into 32 bits.
module dadda_mul16_seq
    import dadda_mul16_seq_pkg::*;
#(
    parameter bit REG_MULT_OUT = 1'b0,
    parameter bit ZERO_SKIP    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    dadda_mul16_seq_if.slave   bus,
    output logic               busy
);
    state_t              state, state_nxt;
    logic [STEP_W-1:0]   step;
    logic [15:0]         a_q, b_q;
    logic [31:0]         acc;
    logic [31:0]         res_q;
    logic                out_valid_q;
    logic [15:0]         prod_q;
    logic [4:0]          prod_sh_q;
    logic                prod_vld_q;

    logic [7:0]          mul_a, mul_b;
    logic [15:0]         mul_x;
    logic [31:0]         step_term;
    logic [31:0]         reg_term;
    logic                accept;
    logic                zero_op;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign busy          = (state != IDLE);

    assign accept  = bus.in_valid && (state == IDLE);
    assign zero_op = ZERO_SKIP && ((bus.a == 16'h0) || (bus.b == 16'h0));

    // Core inputs are held at 0 outside MUL to keep the tree quiet.
    assign mul_a = (state == MUL) ? (step[0] ? a_q[15:8] : a_q[7:0]) : 8'h00;
    assign mul_b = (state == MUL) ? (step[1] ? b_q[15:8] : b_q[7:0]) : 8'h00;

    dadda u_dadda (
        .a (mul_a),
        .b (mul_b),
        .x (mul_x)
    );

    assign step_term = {16'h0, mul_x} << SHIFT_AMT[step];
    assign reg_term  = {16'h0, prod_q} << prod_sh_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = zero_op ? DONE : MUL;
            MUL:   if (step == STEP_W'(NUM_STEPS - 1)) state_nxt = REG_MULT_OUT ? DRAIN : DONE;
            DRAIN: state_nxt = DONE;
            DONE:  if (out_valid_q && bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc         <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            prod_q      <= '0;
            prod_sh_q   <= '0;
            prod_vld_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        acc        <= '0;
                        step       <= '0;
                        prod_vld_q <= 1'b0;
                    end
                end
                MUL: begin
                    step <= step + 1'b1;
                    if (REG_MULT_OUT) begin
                        prod_q     <= mul_x;
                        prod_sh_q  <= 5'(SHIFT_AMT[step]);
                        prod_vld_q <= 1'b1;
                        if (prod_vld_q) acc <= acc + reg_term;
                    end else begin
                        acc <= acc + step_term;
                    end
                end
                DRAIN: begin
                    acc        <= acc + reg_term;
                    prod_vld_q <= 1'b0;
                end
                DONE: begin
                    // First DONE cycle publishes the sum; res then holds until the next publish.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        res_q       <= acc;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dadda_mul16_seq.sv
// Directed and soak bench for dadda_mul16_seq: default build, registered-product build, no-zero-skip build.
module tb_dadda_mul16_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [2:0]  in_valid  = '0;
    logic [2:0]  out_ready = '0;
    logic [15:0] a_drv [3];
    logic [15:0] b_drv [3];
    logic [2:0]  in_ready_w;
    logic [2:0]  out_valid_w;
    logic [2:0]  busy_w;
    logic [31:0] res_w [3];

    dadda_mul16_seq_if if0 ();
    dadda_mul16_seq_if if1 ();
    dadda_mul16_seq_if if2 ();

    assign if0.in_valid = in_valid[0];  assign if0.a = a_drv[0];  assign if0.b = b_drv[0];  assign if0.out_ready = out_ready[0];
    assign if1.in_valid = in_valid[1];  assign if1.a = a_drv[1];  assign if1.b = b_drv[1];  assign if1.out_ready = out_ready[1];
    assign if2.in_valid = in_valid[2];  assign if2.a = a_drv[2];  assign if2.b = b_drv[2];  assign if2.out_ready = out_ready[2];
    assign in_ready_w  = {if2.in_ready, if1.in_ready, if0.in_ready};
    assign out_valid_w = {if2.out_valid, if1.out_valid, if0.out_valid};
    assign res_w[0] = if0.res;
    assign res_w[1] = if1.res;
    assign res_w[2] = if2.res;

    dadda_mul16_seq #(.REG_MULT_OUT(1'b0), .ZERO_SKIP(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave), .busy(busy_w[0]));
    dadda_mul16_seq #(.REG_MULT_OUT(1'b1), .ZERO_SKIP(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave), .busy(busy_w[1]));
    dadda_mul16_seq #(.REG_MULT_OUT(1'b0), .ZERO_SKIP(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave), .busy(busy_w[2]));

    // Called at posedge+1; leaves the bench at posedge+1 right after out_valid is first seen.
    task automatic do_op(input int d, input logic [15:0] av, input logic [15:0] bv,
                         input logic [31:0] er, input int el, input string nm);
        int n;
        n = 0;
        total++;
        if (in_ready_w[d] !== 1'b1) $display("FAIL %s in_ready before accept: got %b want 1", nm, in_ready_w[d]);
        else passed++;
        in_valid[d] = 1'b1;
        a_drv[d]    = av;
        b_drv[d]    = bv;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        a_drv[d]    = 16'hDEAD;
        b_drv[d]    = 16'hBEEF;
        while (out_valid_w[d] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n != el) $display("FAIL %s latency: got %0d want %0d", nm, n, el);
        else passed++;
        total++;
        if (res_w[d] !== er) $display("FAIL %s res: got %h want %h", nm, res_w[d], er);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = '0;
        out_ready = '0;
        for (int i = 0; i < 3; i++) begin a_drv[i] = '0; b_drv[i] = '0; end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        total++; if (in_ready_w !== 3'b111) $display("FAIL reset in_ready: got %b want 111", in_ready_w); else passed++;
        total++; if (out_valid_w !== 3'b000) $display("FAIL reset out_valid: got %b want 000", out_valid_w); else passed++;
        total++; if (res_w[0] !== 32'h0) $display("FAIL reset res: got %h want 00000000", res_w[0]); else passed++;
        total++; if (busy_w !== 3'b000) $display("FAIL reset busy: got %b want 000", busy_w); else passed++;
    endtask

    task automatic test_nominal();
        out_ready[0] = 1'b1;
        do_op(0, 16'h1234, 16'h5678, 32'h06260060, 5, "nominal");
        @(posedge clk); #1;
        total++; if (in_ready_w[0] !== 1'b1) $display("FAIL nominal in_ready after transfer: got %b want 1", in_ready_w[0]); else passed++;
        total++; if (out_valid_w[0] !== 1'b0) $display("FAIL nominal out_valid after transfer: got %b want 0", out_valid_w[0]); else passed++;
    endtask

    task automatic test_max();
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        do_op(0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5, "max_comb");
        @(posedge clk); #1;
        do_op(1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 6, "max_regout");
        @(posedge clk); #1;
        do_op(1, 16'h1234, 16'h5678, 32'h06260060, 6, "nominal_regout");
        @(posedge clk); #1;
    endtask

    task automatic test_zero_skip();
        out_ready[0] = 1'b1;
        out_ready[2] = 1'b1;
        do_op(0, 16'h0000, 16'hABCD, 32'h0, 1, "zero_skip");
        @(posedge clk); #1;
        do_op(2, 16'h0000, 16'hABCD, 32'h0, 5, "zero_noskip");
        @(posedge clk); #1;
        total++; if (in_ready_w[2] !== 1'b1) $display("FAIL zero_noskip in_ready after transfer: got %b want 1", in_ready_w[2]); else passed++;
    endtask

    task automatic test_backpressure();
        out_ready[0] = 1'b0;
        do_op(0, 16'h00FF, 16'h0100, 32'h0000FF00, 5, "backpressure");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid_w[0] !== 1'b1) $display("FAIL bp hold out_valid cyc%0d: got %b want 1", i, out_valid_w[0]); else passed++;
            total++; if (res_w[0] !== 32'h0000FF00) $display("FAIL bp hold res cyc%0d: got %h want 0000ff00", i, res_w[0]); else passed++;
            total++; if (in_ready_w[0] !== 1'b0) $display("FAIL bp hold in_ready cyc%0d: got %b want 0", i, in_ready_w[0]); else passed++;
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid_w[0] !== 1'b0) $display("FAIL bp release out_valid: got %b want 0", out_valid_w[0]); else passed++;
        total++; if (in_ready_w[0] !== 1'b1) $display("FAIL bp release in_ready: got %b want 1", in_ready_w[0]); else passed++;
        total++; if (res_w[0] !== 32'h0000FF00) $display("FAIL bp release res retained: got %h want 0000ff00", res_w[0]); else passed++;
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        out_ready[0] = 1'b1;
        in_valid[0] = 1'b1;
        a_drv[0] = 16'h8001;
        b_drv[0] = 16'h0003;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (in_ready_w[0] !== 1'b1) $display("FAIL rst_mid in_ready: got %b want 1", in_ready_w[0]); else passed++;
        total++; if (out_valid_w[0] !== 1'b0) $display("FAIL rst_mid out_valid: got %b want 0", out_valid_w[0]); else passed++;
        total++; if (res_w[0] !== 32'h0) $display("FAIL rst_mid res: got %h want 00000000", res_w[0]); else passed++;
        total++; if (busy_w[0] !== 1'b0) $display("FAIL rst_mid busy: got %b want 0", busy_w[0]); else passed++;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid_w[0] === 1'b1) pulses++;
        end
        total++; if (pulses != 0) $display("FAIL rst_mid stray out_valid pulses: got %0d want 0", pulses); else passed++;
        do_op(0, 16'h0002, 16'h0003, 32'h00000006, 5, "after_rst");
        @(posedge clk); #1;
    endtask

    task automatic test_soak();
        localparam int N = 1000;
        logic [31:0] expq [$];
        int rcv;
        rcv = 0;
        fork
            begin : producer
                logic [15:0] av, bv;
                logic rdy;
                int waited;
                for (int i = 0; i < N; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    av = 16'($urandom);
                    bv = 16'($urandom);
                    in_valid[0] = 1'b1;
                    a_drv[0] = av;
                    b_drv[0] = bv;
                    waited = 0;
                    forever begin
                        @(negedge clk);
                        rdy = in_ready_w[0];
                        @(posedge clk); #1;
                        if (rdy) break;
                        waited++;
                        if (waited > 200) break;
                    end
                    in_valid[0] = 1'b0;
                    a_drv[0] = 16'h5A5A;
                    b_drv[0] = 16'hA5A5;
                    if (waited > 200) begin
                        total++;
                        $display("FAIL soak accept timeout op%0d: got no accept want accept within 200 cycles", i);
                        break;
                    end
                    expq.push_back(32'(av) * 32'(bv));
                end
            end
            begin : consumer
                int cyc;
                logic [31:0] e;
                cyc = 0;
                while (rcv < N && cyc < 40000) begin
                    @(posedge clk); #1;
                    out_ready[0] = ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                    cyc++;
                    if (busy_w[0] === 1'b1) begin
                        total++;
                        if (in_ready_w[0] !== 1'b0) $display("FAIL soak in_ready while busy: got %b want 0", in_ready_w[0]);
                        else passed++;
                    end
                    if (out_valid_w[0] === 1'b1 && out_ready[0]) begin
                        e = (expq.size() > 0) ? expq.pop_front() : 32'hXXXXXXXX;
                        total++;
                        if (res_w[0] !== e) $display("FAIL soak res #%0d: got %h want %h", rcv, res_w[0], e);
                        else passed++;
                        rcv++;
                    end
                end
                if (rcv < N) begin
                    total++;
                    $display("FAIL soak completion: got %0d results want %0d", rcv, N);
                end
            end
        join
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_max();
        test_zero_skip();
        test_backpressure();
        test_reset_mid();
        test_soak();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
